// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared FSM state encodings and AXI response codes
package axi_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_mem_array.sv
// rtl/axi_mem_array.sv - DEPTH x DATA_WIDTH storage, one sync write port, one async read port
module axi_mem_array #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 256,
    parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // No reset: contents survive a responder reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI-style burst memory responder with independent read and write engines
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 40,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_WIDTH  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);

    w_state_t w_state, w_state_next;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [8:0]            w_left;
    logic                  w_err;
    logic                  aw_hs, w_hs, w_in_range, w_final;

    assign aw_hs      = axi_awvalid && axi_awready;
    assign w_hs       = axi_wvalid && axi_wready;
    assign w_in_range = w_idx < DEPTH_LIMIT;
    assign w_final    = (w_left == 9'd1);

    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state;
        axi_awready  = 1'b0;
        axi_wready   = 1'b0;
        axi_bvalid   = 1'b0;
        axi_bresp    = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                axi_awready = 1'b1;
                if (axi_awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid && w_final) w_state_next = W_RESP;
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                axi_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
                if (axi_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Burst length comes from awlen alone; a misplaced wlast only flags the error.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_idx  <= '0;
            w_left <= '0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_idx  <= axi_awaddr >> WORD_SHIFT;
            w_left <= {1'b0, axi_awlen} + 9'd1;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_idx  <= w_idx + 1'b1;
            w_left <= w_left - 9'd1;
            if (!w_in_range || (axi_wlast != w_final)) w_err <= 1'b1;
        end
    end

    r_state_t r_state, r_state_next;
    logic [ADDR_WIDTH-1:0] r_idx, r_cur;
    logic [8:0]            r_left, r_cur_left;
    logic [7:0]            lat_cnt;
    logic [DATA_WIDTH-1:0] rdata_q, mem_rdata;
    logic                  rlast_q, r_load, ar_hs, r_hs, r_in_range;

    assign ar_hs      = axi_arvalid && axi_arready;
    assign r_hs       = axi_rvalid && axi_rready;
    // With single-cycle latency the first beat loads on the AR handshake itself.
    assign r_cur      = (r_state == R_IDLE) ? (axi_araddr >> WORD_SHIFT) : r_idx;
    assign r_cur_left = (r_state == R_IDLE) ? ({1'b0, axi_arlen} + 9'd1) : r_left;
    assign r_in_range = r_cur < DEPTH_LIMIT;
    assign axi_rdata  = rdata_q;
    assign axi_rlast  = rlast_q;

    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        axi_arready  = 1'b0;
        axi_rvalid   = 1'b0;
        r_load       = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi_arready = 1'b1;
                if (axi_arvalid) begin
                    if (RD_LATENCY <= 1) begin
                        r_state_next = R_DATA;
                        r_load       = 1'b1;
                    end else begin
                        r_state_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt <= 8'd1) begin
                    r_state_next = R_DATA;
                    r_load       = 1'b1;
                end
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                if (axi_rready) begin
                    if (rlast_q) r_state_next = R_IDLE;
                    else         r_load       = 1'b1;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Beats are registered at load time so a stalled beat ignores later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_left  <= '0;
            lat_cnt <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_idx   <= axi_araddr >> WORD_SHIFT;
                r_left  <= {1'b0, axi_arlen} + 9'd1;
                lat_cnt <= 8'(RD_LATENCY - 1);
            end
            if (r_load) begin
                rdata_q <= r_in_range ? mem_rdata : '0;
                rlast_q <= (r_cur_left == 9'd1);
                r_idx   <= r_cur + 1'b1;
                r_left  <= r_cur_left - 9'd1;
            end else if (r_state == R_WAIT) begin
                lat_cnt <= lat_cnt - 8'd1;
            end
            if (r_hs && rlast_q) rlast_q <= 1'b0;
        end
    end

    axi_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_hs && w_in_range),
        .waddr (w_idx[IDX_WIDTH-1:0]),
        .wdata (axi_wdata),
        .raddr (r_cur[IDX_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - directed and randomized bench for axi_mem_responder
module tb_axi_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [39:0]  axi_awaddr;
    logic [7:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [255:0] axi_wdata;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid;
    logic         axi_bready;
    logic [39:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [255:0] axi_rdata;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;

    int checks = 0;
    int failures = 0;
    logic [255:0] model_mem [DEPTH];
    logic [255:0] wbuf [256];

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int j = 0; j < 8; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [255:0] expect_word(input int idx);
        if (idx < DEPTH) return model_mem[idx];
        return '0;
    endfunction

    function automatic logic [1:0] expect_bresp(input logic [39:0] addr, input int len, input int last_at);
        if (last_at != len || int'(addr / 40'd32) + len >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    task automatic do_write(input logic [39:0] addr, input int len, input int last_at, output logic [1:0] resp);
        int n;
        int base;
        base = int'(addr / 40'd32);
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < 50) begin step(); n++; end
        chk("aw_wait", 256'(n < 50), 256'(1));
        step();
        axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(0, 3) == 0) begin axi_wvalid = 1'b0; step(); end
            axi_wdata  = wbuf[b];
            axi_wlast  = (b == last_at);
            axi_wvalid = 1'b1;
            n = 0;
            while (!axi_wready && n < 50) begin step(); n++; end
            chk("w_wait", 256'(n < 50), 256'(1));
            step();
            if (base + b < DEPTH) model_mem[base + b] = wbuf[b];
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            chk("b_hold", 256'(axi_bvalid), 256'(1));
            step();
        end
        axi_bready = 1'b1;
        n = 0;
        while (!axi_bvalid && n < 50) begin step(); n++; end
        chk("b_wait", 256'(n < 50), 256'(1));
        resp = axi_bresp;
        step();
        axi_bready = 1'b0;
        chk("b_drop", 256'(axi_bvalid), 256'(0));
    endtask

    // mode 0: rready held high, 1: pattern then high, 2: random rready
    task automatic do_read(input logic [39:0] addr, input int len, input int mode, input logic [6:0] pat);
        int n;
        int k;
        int cyc;
        int base;
        logic rr;
        base = int'(addr / 40'd32);
        axi_rready  = (mode == 0);
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < 50) begin step(); n++; end
        chk("ar_wait", 256'(n < 50), 256'(1));
        step();
        axi_arvalid = 1'b0;
        n = 1;
        while (!axi_rvalid && n < 20) begin step(); n++; end
        chk("rd_latency", 256'(n), 256'(LAT));
        k = 0;
        cyc = 0;
        while (k <= len && cyc < 400) begin
            if (mode == 0)      rr = 1'b1;
            else if (mode == 1) rr = (cyc < 7) ? pat[6 - cyc] : 1'b1;
            else                rr = 1'($urandom_range(0, 1));
            axi_rready = rr;
            chk("r_valid", 256'(axi_rvalid), 256'(1));
            chk("r_data", axi_rdata, expect_word(base + k));
            chk("r_last", 256'(axi_rlast), 256'(k == len));
            step();
            cyc++;
            if (rr) k++;
        end
        axi_rready = 1'b0;
        chk("r_beats", 256'(k), 256'(len + 1));
        chk("r_idle", 256'(axi_rvalid), 256'(0));
    endtask

    initial begin
        logic [1:0] resp;
        logic [39:0] a;
        int len;
        int last_at;

        rst = 1'b1;
        axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_awready", 256'(axi_awready), 256'(1));
        chk("rst_arready", 256'(axi_arready), 256'(1));
        chk("rst_wready", 256'(axi_wready), 256'(0));
        chk("rst_bvalid", 256'(axi_bvalid), 256'(0));
        chk("rst_bresp", 256'(axi_bresp), 256'(0));
        chk("rst_rvalid", 256'(axi_rvalid), 256'(0));
        chk("rst_rlast", 256'(axi_rlast), 256'(0));
        chk("rst_rdata", axi_rdata, '0);

        for (int i = 0; i < 256; i++) wbuf[i] = rand_word();
        do_write(40'h0, 255, 255, resp);
        chk("fill_bresp", 256'(resp), 256'(2'b00));

        wbuf[0] = rand_word();
        for (int i = 0; i < 4; i++) wbuf[0][i*8 +: 8] = 8'(i + 1);
        do_write(40'h80, 0, 0, resp);
        chk("single_bresp", 256'(resp), 256'(2'b00));
        do_read(40'h80, 0, 0, 7'd0);

        for (int i = 0; i < 4; i++) wbuf[i] = 256'(i + 1);
        do_write(40'h100, 3, 3, resp);
        chk("burst_bresp", 256'(resp), 256'(2'b00));
        for (int i = 0; i < 4; i++) chk("burst_mem", dut.u_mem.mem[8 + i], 256'(i + 1));

        do_read(40'h100, 3, 1, 7'b1001101);

        wbuf[0] = rand_word(); wbuf[1] = rand_word();
        do_write(40'd40 * 32, 1, 0, resp);
        chk("early_wlast_bresp", 256'(resp), 256'(2'b10));
        do_read(40'd40 * 32, 1, 2, 7'd0);

        for (int i = 0; i < 3; i++) wbuf[i] = rand_word();
        do_write(40'd50 * 32 + 40'd7, 2, -1, resp);
        chk("missing_wlast_bresp", 256'(resp), 256'(2'b10));
        do_read(40'd50 * 32, 2, 0, 7'd0);

        wbuf[0] = rand_word();
        do_write(40'(DEPTH * 32), 0, 0, resp);
        chk("oob_bresp", 256'(resp), 256'(2'b10));
        do_read(40'(DEPTH * 32), 0, 0, 7'd0);

        for (int i = 0; i < 4; i++) wbuf[i] = rand_word();
        do_write(40'd254 * 32, 3, 3, resp);
        chk("cross_end_bresp", 256'(resp), 256'(2'b10));
        do_read(40'd254 * 32, 3, 2, 7'd0);

        wbuf[0] = rand_word(); wbuf[1] = rand_word();
        axi_awaddr = 40'd60 * 32; axi_awlen = 8'd3; axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        chk("mid_wready", 256'(axi_wready), 256'(1));
        axi_wdata = wbuf[0]; axi_wlast = 1'b0; axi_wvalid = 1'b1;
        step();
        model_mem[60] = wbuf[0];
        axi_wvalid = 1'b0;
        axi_wdata = wbuf[1];
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_awready", 256'(axi_awready), 256'(1));
        chk("mid_rst_wready", 256'(axi_wready), 256'(0));
        for (int i = 0; i < 6; i++) begin
            chk("mid_rst_bvalid", 256'(axi_bvalid), 256'(0));
            step();
        end
        do_read(40'd60 * 32, 1, 0, 7'd0);

        for (int t = 0; t < 15; t++) begin
            a = 40'($urandom_range(0, 263)) * 32 + 40'($urandom_range(0, 31));
            len = $urandom_range(0, 7);
            last_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
            for (int i = 0; i <= len; i++) wbuf[i] = rand_word();
            do_write(a, len, last_at, resp);
            chk("rand_bresp", 256'(resp), 256'(expect_bresp(a, len, last_at)));
            a = 40'($urandom_range(0, 263)) * 32 + 40'($urandom_range(0, 31));
            do_read(a, $urandom_range(0, 7), 2, 7'd0);
        end

        for (int i = 0; i < DEPTH; i++) chk("final_mem", dut.u_mem.mem[i], model_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
